// File: rtl/calendar_pkg.sv
// Shared constants and types for the calendar blocks: 7-segment patterns,
// set-mode states, edit-field select encodings and field limits.
package calendar_pkg;

  // Active-low segment patterns, bit order gfedcba.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } set_state_t;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_SEC  = 3'b001;
  localparam logic [2:0] SEL_MIN  = 3'b010;
  localparam logic [2:0] SEL_HOUR = 3'b100;

  // Minutes share the seconds limit.
  localparam logic [5:0] MAX_SEC  = 6'd59;
  localparam logic [4:0] MAX_HOUR = 5'd23;

  // One step up or down with wrap between 0 and max_v; no carry out.
  function automatic logic [5:0] step_wrap(input logic [5:0] v,
                                           input logic [5:0] max_v,
                                           input logic       up);
    logic [5:0] r;
    if (up) r = (v == max_v) ? 6'd0 : v + 6'd1;
    else    r = (v == 6'd0)  ? max_v : v - 6'd1;
    return r;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Single decimal digit to active-low 7-segment pattern; non-decimal codes blank.
module seg_decode
  import calendar_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_counter.sv
// Time-of-day counter with button-driven field setting, registered 7-segment
// output, edit-field select and a day-carry pulse for the date counter.
module clock_counter
  import calendar_pkg::*;
#(
  parameter int INIT_H = 0,
  parameter int INIT_M = 0,
  parameter int INIT_S = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        btn_set,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [55:0] clock_7seg,
  output logic [2:0]  sel,
  output logic        day_carry
);

  localparam logic [5:0] INIT_S_V = 6'(INIT_S);
  localparam logic [5:0] INIT_M_V = 6'(INIT_M);
  localparam logic [4:0] INIT_H_V = 5'(INIT_H);

  set_state_t state_reg, state_next;
  logic [5:0] sec_reg, sec_next;
  logic [5:0] min_reg, min_next;
  logic [4:0] hour_reg, hour_next;
  logic       roll_reg, roll_next;
  logic       day_carry_reg;
  logic [2:0] sel_reg, sel_next;
  logic [55:0] seg_reg, seg_next;

  logic       adj;
  logic [5:0] hour_step;

  always_comb begin
    state_next = state_reg;
    sec_next   = sec_reg;
    min_next   = min_reg;
    hour_next  = hour_reg;
    roll_next  = 1'b0;
    adj        = btn_up ^ btn_down;
    hour_step  = step_wrap({1'b0, hour_reg}, {1'b0, MAX_HOUR}, btn_up);

    unique case (state_reg)
      RUN: begin
        if (tick_1hz) begin
          if (sec_reg == MAX_SEC) begin
            sec_next = 6'd0;
            if (min_reg == MAX_SEC) begin
              min_next = 6'd0;
              if (hour_reg == MAX_HOUR) begin
                hour_next = 5'd0;
                roll_next = 1'b1;
              end else begin
                hour_next = hour_reg + 5'd1;
              end
            end else begin
              min_next = min_reg + 6'd1;
            end
          end else begin
            sec_next = sec_reg + 6'd1;
          end
        end
        if (btn_set) state_next = SET_H;
      end
      SET_H: begin
        if (adj) hour_next = hour_step[4:0];
        if (btn_set) state_next = SET_M;
      end
      SET_M: begin
        if (adj) min_next = step_wrap(min_reg, MAX_SEC, btn_up);
        if (btn_set) state_next = SET_S;
      end
      SET_S: begin
        if (adj) sec_next = step_wrap(sec_reg, MAX_SEC, btn_up);
        if (btn_set) state_next = RUN;
      end
    endcase
  end

  always_comb begin
    sel_next = SEL_NONE;
    unique case (state_reg)
      RUN:   sel_next = SEL_NONE;
      SET_H: sel_next = SEL_HOUR;
      SET_M: sel_next = SEL_MIN;
      SET_S: sel_next = SEL_SEC;
    endcase
  end

  // The display source follows the INIT values while rst is high, so the
  // first registered word after reset already shows the initial time.
  logic [5:0] field_val [3];
  logic [3:0] digits    [6];
  logic [6:0] seg_dig   [6];

  assign field_val[0] = rst ? INIT_S_V : sec_reg;
  assign field_val[1] = rst ? INIT_M_V : min_reg;
  assign field_val[2] = rst ? {1'b0, INIT_H_V} : {1'b0, hour_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_split
      logic [5:0] v;
      logic [3:0] tens;
      logic [3:0] units;
      assign v = field_val[gi];
      always_comb begin
        tens  = 4'd0;
        units = v[3:0];
        if (v >= 6'd50) begin
          tens  = 4'd5;
          units = 4'(v - 6'd50);
        end else if (v >= 6'd40) begin
          tens  = 4'd4;
          units = 4'(v - 6'd40);
        end else if (v >= 6'd30) begin
          tens  = 4'd3;
          units = 4'(v - 6'd30);
        end else if (v >= 6'd20) begin
          tens  = 4'd2;
          units = 4'(v - 6'd20);
        end else if (v >= 6'd10) begin
          tens  = 4'd1;
          units = 4'(v - 6'd10);
        end
      end
      assign digits[2*gi]   = units;
      assign digits[2*gi+1] = tens;
    end

    for (gi = 0; gi < 6; gi++) begin : g_seg
      seg_decode u_dec (
        .digit (digits[gi]),
        .seg   (seg_dig[gi])
      );
      assign seg_next[7*gi +: 7] = seg_dig[gi];
    end
  endgenerate

  assign seg_next[55:42] = {SEG_BLANK, SEG_BLANK};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      sec_reg       <= INIT_S_V;
      min_reg       <= INIT_M_V;
      hour_reg      <= INIT_H_V;
      roll_reg      <= 1'b0;
      day_carry_reg <= 1'b0;
      sel_reg       <= SEL_NONE;
    end else begin
      state_reg     <= state_next;
      sec_reg       <= sec_next;
      min_reg       <= min_next;
      hour_reg      <= hour_next;
      roll_reg      <= roll_next;
      // Delayed one stage so the pulse lines up with the 00:00:00 display.
      day_carry_reg <= roll_reg;
      sel_reg       <= sel_next;
    end
  end

  always_ff @(posedge clk) begin
    seg_reg <= seg_next;
  end

  assign clock_7seg = seg_reg;
  assign sel        = sel_reg;
  assign day_carry  = day_carry_reg;

endmodule

// File: tb/tb_clock_counter.sv
// Directed bench for clock_counter: two instances (default INIT and 23:59:58)
// share stimulus; each scenario task checks outputs against hand-built values.
module tb_clock_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        btn_set = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic [55:0] seg_a, seg_b;
  logic [2:0]  sel_a, sel_b;
  logic        dc_a, dc_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clock_counter u_dut_a (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_set(btn_set),
    .btn_up(btn_up), .btn_down(btn_down),
    .clock_7seg(seg_a), .sel(sel_a), .day_carry(dc_a)
  );

  clock_counter #(.INIT_H(23), .INIT_M(59), .INIT_S(58)) u_dut_b (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_set(btn_set),
    .btn_up(btn_up), .btn_down(btn_down),
    .clock_7seg(seg_b), .sel(sel_b), .day_carry(dc_b)
  );

  function automatic logic [55:0] exp_word(input int h, input int m, input int s);
    logic [6:0] pat [10];
    pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return {7'h7F, 7'h7F, pat[h/10], pat[h%10], pat[m/10], pat[m%10],
            pat[s/10], pat[s%10]};
  endfunction

  task automatic step(input logic t, input logic s, input logic u, input logic d);
    tick_1hz = t; btn_set = s; btn_up = u; btn_down = d;
    @(posedge clk); #1;
    tick_1hz = 1'b0; btn_set = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (seg_a !== exp_word(0, 0, 0)) begin
      n_fail++; $display("FAIL reset_seg_a: got %h want %h", seg_a, exp_word(0, 0, 0));
    end
    n_checks++;
    if (seg_b !== exp_word(23, 59, 58)) begin
      n_fail++; $display("FAIL reset_seg_b: got %h want %h", seg_b, exp_word(23, 59, 58));
    end
    n_checks++;
    if (sel_a !== 3'b000 || dc_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_sel_dc: got sel=%b dc=%b want 000/0", sel_a, dc_a);
    end
    $display("test_reset done");
  endtask

  task automatic test_count();
    do_reset();
    for (int i = 0; i < 61; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    n_checks++;
    if (seg_a[13:0] !== {7'h40, 7'h79}) begin
      n_fail++; $display("FAIL count_sec_digits: got %h want %h", seg_a[13:0], {7'h40, 7'h79});
    end
    n_checks++;
    if (seg_a[55:42] !== {7'h7F, 7'h7F}) begin
      n_fail++; $display("FAIL count_blank: got %h want %h", seg_a[55:42], {7'h7F, 7'h7F});
    end
    n_checks++;
    if (seg_a !== exp_word(0, 1, 1) || sel_a !== 3'b000) begin
      n_fail++; $display("FAIL count_word: got %h sel=%b want %h sel=000", seg_a, sel_a, exp_word(0, 1, 1));
    end
    $display("test_count done");
  endtask

  task automatic test_rollover();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    n_checks++;
    if (seg_b !== exp_word(23, 59, 59) || dc_b !== 1'b0) begin
      n_fail++; $display("FAIL roll_first_tick: got %h dc=%b want %h dc=0", seg_b, dc_b, exp_word(23, 59, 59));
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (dc_b !== 1'b0) begin
      n_fail++; $display("FAIL roll_early: got dc=%b want 0", dc_b);
    end
    idle(1);
    n_checks++;
    if (dc_b !== 1'b1 || seg_b !== exp_word(0, 0, 0)) begin
      n_fail++; $display("FAIL roll_pulse: got dc=%b seg=%h want 1 %h", dc_b, seg_b, exp_word(0, 0, 0));
    end
    idle(1);
    n_checks++;
    if (dc_b !== 1'b0) begin
      n_fail++; $display("FAIL roll_width: got dc=%b want 0", dc_b);
    end
    $display("test_rollover done");
  endtask

  task automatic test_set_hour();
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    n_checks++;
    if (sel_a !== 3'b100) begin
      n_fail++; $display("FAIL seth_sel: got %b want 100", sel_a);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    n_checks++;
    if (seg_a !== exp_word(23, 0, 0) || dc_a !== 1'b0) begin
      n_fail++; $display("FAIL seth_down: got %h dc=%b want %h dc=0", seg_a, dc_a, exp_word(23, 0, 0));
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    n_checks++;
    if (sel_a !== 3'b010) begin
      n_fail++; $display("FAIL seth_to_m: got %b want 010", sel_a);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    n_checks++;
    if (sel_a !== 3'b001) begin
      n_fail++; $display("FAIL seth_to_s: got %b want 001", sel_a);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    n_checks++;
    if (sel_a !== 3'b000) begin
      n_fail++; $display("FAIL seth_to_run: got %b want 000", sel_a);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    n_checks++;
    if (seg_a !== exp_word(23, 0, 1)) begin
      n_fail++; $display("FAIL run_resume_ignore_up: got %h want %h", seg_a, exp_word(23, 0, 1));
    end
    $display("test_set_hour done");
  endtask

  task automatic test_set_minute_and_reset();
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    n_checks++;
    if (sel_b !== 3'b010) begin
      n_fail++; $display("FAIL setm_sel: got %b want 010", sel_b);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);
    n_checks++;
    if (seg_b !== exp_word(23, 59, 58)) begin
      n_fail++; $display("FAIL setm_up_down: got %h want %h", seg_b, exp_word(23, 59, 58));
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    n_checks++;
    if (seg_b !== exp_word(23, 0, 58) || dc_b !== 1'b0) begin
      n_fail++; $display("FAIL setm_wrap_up: got %h dc=%b want %h dc=0", seg_b, dc_b, exp_word(23, 0, 58));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    n_checks++;
    if (seg_b !== exp_word(23, 59, 58)) begin
      n_fail++; $display("FAIL setm_wrap_down: got %h want %h", seg_b, exp_word(23, 59, 58));
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    n_checks++;
    if (seg_b !== exp_word(23, 0, 58) || sel_b !== 3'b001) begin
      n_fail++; $display("FAIL setm_set_with_up: got %h sel=%b want %h sel=001", seg_b, sel_b, exp_word(23, 0, 58));
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    n_checks++;
    if (seg_b !== exp_word(23, 0, 0) || dc_b !== 1'b0) begin
      n_fail++; $display("FAIL sets_wrap_no_carry: got %h dc=%b want %h dc=0", seg_b, dc_b, exp_word(23, 0, 0));
    end
    do_reset();
    n_checks++;
    if (sel_b !== 3'b000 || seg_b !== exp_word(23, 59, 58)) begin
      n_fail++; $display("FAIL midset_reset: got sel=%b seg=%h want 000 %h", sel_b, seg_b, exp_word(23, 59, 58));
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    n_checks++;
    if (seg_b !== exp_word(23, 59, 59)) begin
      n_fail++; $display("FAIL midset_resume: got %h want %h", seg_b, exp_word(23, 59, 59));
    end
    $display("test_set_minute_and_reset done");
  endtask

  task automatic test_tick_with_set();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    n_checks++;
    if (seg_a !== exp_word(0, 0, 5)) begin
      n_fail++; $display("FAIL tickset_pre: got %h want %h", seg_a, exp_word(0, 0, 5));
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (sel_a !== 3'b000) begin
      n_fail++; $display("FAIL tickset_sel_latency: got %b want 000", sel_a);
    end
    idle(1);
    n_checks++;
    if (seg_a !== exp_word(0, 0, 6) || sel_a !== 3'b100) begin
      n_fail++; $display("FAIL tickset_both: got %h sel=%b want %h sel=100", seg_a, sel_a, exp_word(0, 0, 6));
    end
    $display("test_tick_with_set done");
  endtask

  initial begin
    test_reset();
    test_count();
    test_rollover();
    test_set_hour();
    test_set_minute_and_reset();
    test_tick_with_set();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
